// File: rtl/date_pkg.sv
// Shared widths, reset date, month numbers and the month_len helper for date_cnt.
// Leap-year handling is selected by the DATE_CNT_LEAP_YEAR_EN macro.
package date_pkg;

   localparam int DAY_W   = 5;
   localparam int MONTH_W = 4;
   localparam int YEAR_W  = 7;

   localparam logic [DAY_W-1:0]   RST_DAY   = 5'd1;
   localparam logic [MONTH_W-1:0] RST_MONTH = 4'd1;
   localparam logic [YEAR_W-1:0]  RST_YEAR  = 7'd0;
   localparam logic [YEAR_W-1:0]  YEAR_MAX  = 7'd99;

   localparam logic [MONTH_W-1:0] MON_JAN = 4'd1;
   localparam logic [MONTH_W-1:0] MON_FEB = 4'd2;
   localparam logic [MONTH_W-1:0] MON_MAR = 4'd3;
   localparam logic [MONTH_W-1:0] MON_APR = 4'd4;
   localparam logic [MONTH_W-1:0] MON_MAY = 4'd5;
   localparam logic [MONTH_W-1:0] MON_JUN = 4'd6;
   localparam logic [MONTH_W-1:0] MON_JUL = 4'd7;
   localparam logic [MONTH_W-1:0] MON_AUG = 4'd8;
   localparam logic [MONTH_W-1:0] MON_SEP = 4'd9;
   localparam logic [MONTH_W-1:0] MON_OCT = 4'd10;
   localparam logic [MONTH_W-1:0] MON_NOV = 4'd11;
   localparam logic [MONTH_W-1:0] MON_DEC = 4'd12;

`ifdef DATE_CNT_LEAP_YEAR_EN
   localparam bit LEAP_EN = 1'b1;
`else
   localparam bit LEAP_EN = 1'b0;
`endif

   // Only the two low year bits matter: within 2000-2099 every multiple of 4 is a leap year.
   // Returns 0 for an illegal month so any day fails the range check.
   function automatic logic [DAY_W-1:0] month_len(input logic [MONTH_W-1:0] m,
                                                  input logic [1:0]         y_lo);
      case (m)
         MON_JAN, MON_MAR, MON_MAY, MON_JUL,
         MON_AUG, MON_OCT, MON_DEC:          month_len = 5'd31;
         MON_APR, MON_JUN, MON_SEP, MON_NOV: month_len = 5'd30;
         MON_FEB:  month_len = (LEAP_EN && (y_lo == 2'b00)) ? 5'd29 : 5'd28;
         default:  month_len = 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Synchronizes an asynchronous level into clk and emits a one-cycle tick per rising edge.
module sync_edge
   import date_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic tick
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Combinational from flops only, so the date register sees the tick on edge SYNC_STAGES.
   assign tick = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/date_cnt.sv
// Calendar date counter (2000-2099) advanced by an asynchronous day carry, with checked loads.
// Leap-year February is enabled by defining DATE_CNT_LEAP_YEAR_EN.
module date_cnt
   import date_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               day_clk,
   input  logic               set_en,
   input  logic [DAY_W-1:0]   set_day,
   input  logic [MONTH_W-1:0] set_month,
   input  logic [YEAR_W-1:0]  set_year,
   output logic [DAY_W-1:0]   day,
   output logic [MONTH_W-1:0] month,
   output logic [YEAR_W-1:0]  year,
   output logic               out_clk,
   output logic               set_err
);

   logic             tick;
   logic [DAY_W-1:0] cur_len;
   logic [DAY_W-1:0] set_len;
   logic             set_ok;

   sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk  (clk),
      .rst  (rst),
      .din  (day_clk),
      .tick (tick)
   );

   always_comb begin
      cur_len = month_len(month, year[1:0]);
      set_len = month_len(set_month, set_year[1:0]);
      set_ok  = (set_month >= MON_JAN) && (set_month <= MON_DEC) &&
                (set_year <= YEAR_MAX) && (set_day != '0) && (set_day <= set_len);
   end

   // A load always beats a coincident tick; the tick is dropped, not queued.
   always_ff @(posedge clk) begin
      if (rst) begin
         day     <= RST_DAY;
         month   <= RST_MONTH;
         year    <= RST_YEAR;
         out_clk <= 1'b0;
         set_err <= 1'b0;
      end else begin
         out_clk <= 1'b0;
         set_err <= 1'b0;
         if (set_en) begin
            if (set_ok) begin
               day   <= set_day;
               month <= set_month;
               year  <= set_year;
            end else begin
               set_err <= 1'b1;
            end
         end else if (tick) begin
            if (day < cur_len) begin
               day <= day + 5'd1;
            end else if (month < MON_DEC) begin
               day   <= RST_DAY;
               month <= month + 4'd1;
            end else begin
               day     <= RST_DAY;
               month   <= MON_JAN;
               year    <= (year == YEAR_MAX) ? '0 : year + 7'd1;
               out_clk <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_date_cnt.sv
// Directed self-checking bench for date_cnt; expectations follow DATE_CNT_LEAP_YEAR_EN.
module tb_date_cnt;

   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       day_clk;
   logic       set_en;
   logic [4:0] set_day;
   logic [3:0] set_month;
   logic [6:0] set_year;
   logic [4:0] day;
   logic [3:0] month;
   logic [6:0] year;
   logic       out_clk;
   logic       set_err;

   int total = 0;
   int bad   = 0;
   int oc_cnt  = 0;
   int err_cnt = 0;
   int err_exp = 0;

   always #5 clk = ~clk;

   date_cnt #(
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .day_clk   (day_clk),
      .set_en    (set_en),
      .set_day   (set_day),
      .set_month (set_month),
      .set_year  (set_year),
      .day       (day),
      .month     (month),
      .year      (year),
      .out_clk   (out_clk),
      .set_err   (set_err)
   );

   always @(negedge clk) begin
      if (out_clk) oc_cnt++;
      if (set_err) err_cnt++;
   end

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_date(input string tag, input int d, input int m, input int y);
      check({tag, ".day"},   int'(day),   d);
      check({tag, ".month"}, int'(month), m);
      check({tag, ".year"},  int'(year),  y);
   endtask

   // Called at a negedge; returns at the negedge right after the loading posedge.
   task automatic set_date(input logic [4:0] d, input logic [3:0] m, input logic [6:0] y);
      set_en    = 1'b1;
      set_day   = d;
      set_month = m;
      set_year  = y;
      @(negedge clk);
      set_en    = 1'b0;
   endtask

   task automatic reject(input string tag, input logic [4:0] d, input logic [3:0] m,
                         input logic [6:0] y);
      int pd, pm, py;
      pd = int'(day); pm = int'(month); py = int'(year);
      set_date(d, m, y);
      err_exp++;
      check({tag, ".err"}, int'(set_err), 1);
      check_date(tag, pd, pm, py);
      @(negedge clk);
      check({tag, ".err_drop"}, int'(set_err), 0);
   endtask

   // One full day_clk pulse; the low phase is long enough to re-arm the detector.
   task automatic day_pulse();
      day_clk = 1'b1;
      repeat (SYNC + 2) @(negedge clk);
      day_clk = 1'b0;
      repeat (SYNC + 2) @(negedge clk);
   endtask

   initial begin
      int oc0;
      rst = 1'b1; day_clk = 1'b0; set_en = 1'b0;
      set_day = '0; set_month = '0; set_year = '0;
      repeat (3) @(negedge clk);
      check_date("reset", 1, 1, 0);
      check("reset.out_clk", int'(out_clk), 0);
      check("reset.set_err", int'(set_err), 0);
      rst = 1'b0;
      @(negedge clk);

      // Latency: update on the edge SYNC cycles after the first sampling edge.
      day_clk = 1'b1;
      repeat (SYNC) @(negedge clk);
      check("lat.before", int'(day), 1);
      @(negedge clk);
      check_date("lat.after", 2, 1, 0);
      repeat (6) @(negedge clk);
      check_date("lat.held", 2, 1, 0);
      day_clk = 1'b0;
      repeat (SYNC + 2) @(negedge clk);

      set_date(5'd31, 4'd1, 7'd0);
      check("jan31.err", int'(set_err), 0);
      check_date("jan31.load", 31, 1, 0);
      day_pulse();
      check_date("jan31.tick", 1, 2, 0);

      set_date(5'd28, 4'd2, 7'd1);
      day_pulse();
      check_date("feb28_01.tick", 1, 3, 1);

      set_date(5'd28, 4'd2, 7'd4);
      day_pulse();
`ifdef DATE_CNT_LEAP_YEAR_EN
      check_date("feb28_04.tick", 29, 2, 4);
      day_pulse();
      check_date("feb29_04.tick", 1, 3, 4);
      set_date(5'd29, 4'd2, 7'd8);
      check("feb29_08.err", int'(set_err), 0);
      check_date("feb29_08.load", 29, 2, 8);
`else
      check_date("feb28_04.tick", 1, 3, 4);
      reject("feb29_08", 5'd29, 4'd2, 7'd8);
`endif
      reject("feb29_01", 5'd29, 4'd2, 7'd1);

      oc0 = oc_cnt;
      set_date(5'd31, 4'd12, 7'd99);
      check_date("dec31_99.load", 31, 12, 99);
      day_pulse();
      check_date("dec31_99.tick", 1, 1, 0);
      check("dec31_99.out_clk_cycles", oc_cnt - oc0, 1);

      set_date(5'd10, 4'd5, 7'd20);
      reject("month13", 5'd10, 4'd13, 7'd20);
      reject("apr31",   5'd31, 4'd4,  7'd20);
      reject("year100", 5'd10, 4'd5,  7'd100);
      reject("day0",    5'd0,  4'd5,  7'd20);
      reject("month0",  5'd10, 4'd0,  7'd20);

      // Load on the same edge the tick arrives: loaded value, tick discarded.
      day_clk = 1'b1;
      repeat (SYNC) @(negedge clk);
      set_date(5'd15, 4'd6, 7'd10);
      check_date("coinc.load", 15, 6, 10);
      repeat (4) @(negedge clk);
      day_clk = 1'b0;
      repeat (SYNC + 4) @(negedge clk);
      check_date("coinc.no_inc", 15, 6, 10);

      // Edge in flight when reset hits must vanish.
      day_clk = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      day_clk = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_date("inflight.reset", 1, 1, 0);
      repeat (SYNC + 4) @(negedge clk);
      check_date("inflight.no_tick", 1, 1, 0);

      // day_clk already high across reset release produces exactly one tick.
      day_clk = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (SYNC + 4) @(negedge clk);
      check_date("high_at_release", 2, 1, 0);
      day_clk = 1'b0;
      repeat (SYNC + 2) @(negedge clk);

      check("total.out_clk_cycles", oc_cnt, 1);
      check("total.set_err_cycles", err_cnt, err_exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
